// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment scanner with leading-zero blanking, PM dot and alarm blink.
// Requests digits by index (rr) and latches the looked-up value two cycles later.
module seg_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [4:0] digit_holder,
    input  logic       enable,
    input  logic       TOD,
    input  logic       time_format,
    output logic [2:0] rr,
    output logic [7:0] AN,
    output logic [6:0] seg,
    output logic       DP,
    output logic       alarm_led
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {StAdv, StWait, StLatch, StShow} state_e;

    state_e          state_q;
    logic [PW-1:0]   presc_q;
    logic [2:0]      rr_q;
    logic [2:0]      cap_rr_q;
    logic            cap_tf_q;
    logic            cap_tod_q;
    logic [7:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic            en_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            phase_q;

    logic            presc_wrap;
    logic            blink_wrap;
    logic            en_rise;
    logic [6:0]      seg_next;

    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'h40;
            5'd1:    decode = 7'h79;
            5'd2:    decode = 7'h24;
            5'd3:    decode = 7'h30;
            5'd4:    decode = 7'h19;
            5'd5:    decode = 7'h12;
            5'd6:    decode = 7'h02;
            5'd7:    decode = 7'h78;
            5'd8:    decode = 7'h00;
            5'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        presc_wrap = (presc_q == PW'(REFRESH_DIV - 1));
        blink_wrap = (blink_cnt_q == BW'(BLINK_DIV - 1));
        en_rise    = enable & ~en_q;
        // Hour-tens zero is blanked in 12-hour mode
        if (rr_q == 3'd0 && time_format && digit_holder == 5'd0) begin
            seg_next = 7'h7F;
        end else begin
            seg_next = decode(digit_holder);
        end
    end

    // Scan FSM; AN and DP are registered from the current state so they follow SHOW by one cycle.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= StAdv;
            presc_q   <= '0;
            rr_q      <= 3'd0;
            cap_rr_q  <= 3'd0;
            cap_tf_q  <= 1'b0;
            cap_tod_q <= 1'b0;
            an_q      <= 8'hFF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            an_q    <= 8'hFF;
            dp_q    <= 1'b1;
            unique case (state_q)
                StAdv:   state_q <= StWait;
                StWait:  state_q <= StLatch;
                StLatch: begin
                    cap_rr_q  <= rr_q;
                    cap_tf_q  <= time_format;
                    cap_tod_q <= TOD;
                    seg_q     <= seg_next;
                    state_q   <= StShow;
                end
                StShow: begin
                    an_q <= ~(8'h80 >> cap_rr_q);
                    dp_q <= ~(cap_rr_q == 3'd7 && cap_tf_q && !cap_tod_q);
                    if (presc_wrap) begin
                        rr_q    <= rr_q + 3'd1;
                        state_q <= StAdv;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            en_q        <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            en_q <= enable;
            if (en_rise || !en_q) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b1;
            end else if (enable) begin
                if (blink_wrap) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    assign rr        = rr_q;
    assign seg       = seg_q;
    assign DP        = dp_q;
    assign alarm_led = en_q & phase_q;
    assign AN        = (en_q && !phase_q) ? 8'hFF : an_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: constant tables for decode and frame order, hand sequences for
// reset/blink/PM corners, and a cycle-indexed reference model under random stimulus.
module tb_seg_scan;

    localparam int unsigned RD = 8;
    localparam int unsigned BD = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] digit_holder;
    logic       enable;
    logic       TOD;
    logic       time_format;
    logic [2:0] rr;
    logic [7:0] AN;
    logic [6:0] seg;
    logic       DP;
    logic       alarm_led;

    always #5 clk = ~clk;

    seg_scan #(
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .digit_holder(digit_holder),
        .enable      (enable),
        .TOD         (TOD),
        .time_format (time_format),
        .rr          (rr),
        .AN          (AN),
        .seg         (seg),
        .DP          (DP),
        .alarm_led   (alarm_led)
    );

    typedef struct {
        logic [4:0] code;
        logic       tf;
        int         slot;
        logic [6:0] exp_seg;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tbl [10];
    logic [4:0] digits  [8];
    vec_t       vecs    [15];
    logic [7:0] frame_an  [8];
    logic [6:0] frame_seg [8];

    // Reference model: n counts rising edges since reset release.
    int         n;
    logic [2:0] m_slot;
    logic       m_tf;
    logic       m_tod;
    logic [6:0] m_seg;
    logic       m_enq;
    int         m_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [4:0] code, input logic blank_zero);
        if (code > 5'd9 || (blank_zero && code == 5'd0)) return 7'h7F;
        return seg_tbl[code[3:0]];
    endfunction

    function automatic void model_reset();
        n      = 0;
        m_slot = 3'd0;
        m_tf   = 1'b0;
        m_tod  = 1'b0;
        m_seg  = 7'h7F;
        m_enq  = 1'b0;
        m_k    = 0;
    endfunction

    task automatic step();
        int         p;
        int         slot;
        logic [7:0] e_an;
        logic       e_led;
        logic       show;
        logic [4:0] pc;
        logic       pen;
        logic       ptf;
        logic       ptod;
        pc   = digit_holder;
        pen  = enable;
        ptf  = time_format;
        ptod = TOD;
        @(posedge clk);
        #1;
        n++;
        p    = (n - 1) % 8;
        slot = ((n - 1) / 8) % 8;
        if (p == 2) begin
            m_slot = 3'(slot);
            m_tf   = ptf;
            m_tod  = ptod;
            m_seg  = ref_seg(pc, slot == 0 && ptf);
        end
        if (pen && !m_enq) m_k = 0;
        else if (pen && m_enq) m_k++;
        m_enq = pen;
        e_led = m_enq && ((m_k / BD) % 2 == 0);
        show  = (p >= 3);
        e_an  = 8'hFF;
        if (show) e_an[7 - m_slot] = 1'b0;
        if (m_enq && !e_led) e_an = 8'hFF;
        check("rr", rr, (n / 8) % 8);
        check("AN", AN, e_an);
        check("seg", seg, m_seg);
        check("DP", DP, !(show && m_slot == 3'd7 && m_tf && !m_tod));
        check("alarm_led", alarm_led, e_led);
        check("an_onehot", $countones(~AN) <= 1, 1);
        digit_holder = digits[rr];
    endtask

    task automatic run_to(input int s, input int ph);
        for (int i = 0; i < 80; i++) begin
            step();
            if (((n - 1) % 8) == ph && (((n - 1) / 8) % 8) == s) return;
        end
        tests++;
        fails++;
        $display("FAIL run_to: slot %0d phase %0d not reached, got edge %0d", s, ph, n);
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        digits  = '{5'd1, 5'd2, 5'd16, 5'd3, 5'd4, 5'd16, 5'd5, 5'd6};
        frame_an  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        frame_seg = '{7'h79, 7'h24, 7'h7F, 7'h30, 7'h19, 7'h7F, 7'h12, 7'h02};
        vecs[0]  = '{5'd0,  1'b0, 3, 7'h40};
        vecs[1]  = '{5'd1,  1'b0, 1, 7'h79};
        vecs[2]  = '{5'd2,  1'b0, 2, 7'h24};
        vecs[3]  = '{5'd3,  1'b0, 4, 7'h30};
        vecs[4]  = '{5'd4,  1'b0, 5, 7'h19};
        vecs[5]  = '{5'd5,  1'b0, 6, 7'h12};
        vecs[6]  = '{5'd6,  1'b0, 7, 7'h02};
        vecs[7]  = '{5'd7,  1'b0, 0, 7'h78};
        vecs[8]  = '{5'd8,  1'b0, 1, 7'h00};
        vecs[9]  = '{5'd9,  1'b0, 2, 7'h10};
        vecs[10] = '{5'd10, 1'b0, 3, 7'h7F};
        vecs[11] = '{5'd16, 1'b0, 4, 7'h7F};
        vecs[12] = '{5'd31, 1'b0, 5, 7'h7F};
        vecs[13] = '{5'd0,  1'b1, 0, 7'h7F};
        vecs[14] = '{5'd0,  1'b1, 6, 7'h40};

        // Reset with busy inputs: outputs must ignore them
        rst_n = 1'b0; enable = 1'b1; TOD = 1'b0; time_format = 1'b1; digit_holder = 5'd8;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rr", rr, 0);
        check("rst_AN", AN, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_DP", DP, 1);
        check("rst_led", alarm_led, 0);
        enable = 1'b0; TOD = 1'b1; time_format = 1'b0; digit_holder = digits[0];
        rst_n = 1'b1;

        step(); step(); step();
        check("first_an_edge3", AN, 8'hFF);
        step();
        check("first_an_edge4", AN, 8'h7F);

        for (int s = 0; s < 8; s++) begin
            run_to(s, 4);
            check($sformatf("frame_an%0d", s), AN, frame_an[s]);
            check($sformatf("frame_seg%0d", s), seg, frame_seg[s]);
        end

        foreach (vecs[i]) begin
            for (int d = 0; d < 8; d++) digits[d] = vecs[i].code;
            digit_holder = vecs[i].code;
            time_format  = vecs[i].tf;
            run_to(vecs[i].slot, 3);
            check($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
        end

        // 12-hour PM: hour-tens zero blanked, dot on slot 7; AM clears the dot
        for (int d = 0; d < 8; d++) digits[d] = 5'd7;
        digits[0] = 5'd0; time_format = 1'b1; TOD = 1'b0;
        run_to(0, 4);
        check("lz_seg", seg, 7'h7F);
        run_to(7, 4);
        check("pm_dp", DP, 0);
        TOD = 1'b1;
        run_to(7, 4);
        check("am_dp", DP, 1);

        // Alarm blink from an arbitrary cycle
        repeat ($urandom_range(0, 7)) step();
        enable = 1'b1;
        step();
        for (int i = 0; i < 96; i++) begin
            check("blink_led", alarm_led, ((i / 32) % 2) == 0);
            if (((i / 32) % 2) == 1) check("blink_an_off", AN, 8'hFF);
            step();
        end
        enable = 1'b0;
        step();
        check("fall_led", alarm_led, 0);

        // Asynchronous reset mid-SHOW of slot 4
        run_to(4, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_AN", AN, 8'hFF);
        check("midrst_rr", rr, 0);
        check("midrst_seg", seg, 7'h7F);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        digit_holder = digits[0];
        run_to(0, 4);
        check("restart_an", AN, 8'h7F);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if (i % 64 == 0) begin
                for (int d = 0; d < 8; d++) begin
                    digits[d] = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'(($urandom_range(0, 12)));
                end
            end
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) time_format = ~time_format;
            if ($urandom_range(0, 49) == 0) TOD = ~TOD;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
